// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: moves bytes from a FIFO into a UART transmitter one
// frame at a time. It pops a byte, latches it, strobes tx_start, waits for
// the transmitter to acknowledge with tx_busy and then to finish, and
// enforces an idle gap between frames. It also keeps a count of completed
// frames and a sticky flag that records when an acknowledge never arrived.
module uart_tx_scheduler #(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 16,
  parameter int ACK_TO  = 16,
  parameter int GAP_CYC = 0
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              enable,
  input  logic              err_clr,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic [CNT_W-1:0]  sent_count,
  output logic              ack_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_POP,
    S_LATCH,
    S_START,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

  localparam logic [7:0] ACK_INIT = 8'(ACK_TO);
  localparam logic [7:0] GAP_INIT = 8'(GAP_CYC);

  state_t              state_q;
  logic                rd_en_q;
  logic                start_q;
  logic [DATA_W-1:0]   tx_data_q;
  logic                busy_q;
  logic [CNT_W-1:0]    sent_q;
  logic                err_q;
  logic [7:0]          ack_q;
  logic [7:0]          gap_q;

  // Frame sequencer. Strobes and busy are registered, so each one is set
  // on the edge that enters the state it belongs to.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q   <= S_IDLE;
      rd_en_q   <= 1'b0;
      start_q   <= 1'b0;
      tx_data_q <= '0;
      busy_q    <= 1'b0;
      sent_q    <= '0;
      err_q     <= 1'b0;
      ack_q     <= '0;
      gap_q     <= '0;
    end else begin
      rd_en_q <= 1'b0;
      start_q <= 1'b0;
      // A timeout set later in this block overrides the clear.
      if (err_clr) begin
        err_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (enable && !fifo_empty) begin
            state_q <= S_POP;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_POP: begin
          state_q <= S_LATCH;
        end
        S_LATCH: begin
          tx_data_q <= fifo_data;
          state_q   <= S_START;
          start_q   <= 1'b1;
        end
        S_START: begin
          ack_q   <= ACK_INIT;
          state_q <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (tx_busy) begin
            state_q <= S_WAIT_DONE;
          end else begin
            ack_q <= ack_q - 8'd1;
            if (ack_q <= 8'd1) begin
              err_q   <= 1'b1;
              gap_q   <= GAP_INIT;
              state_q <= S_GAP;
            end
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            sent_q  <= sent_q + CNT_W'(1);
            gap_q   <= GAP_INIT;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_q == 8'd0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx_start   = start_q;
  assign tx_data    = tx_data_q;
  assign busy       = busy_q;
  assign sent_count = sent_q;
  assign ack_err    = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed bench for uart_tx_scheduler with a FIFO
// model and a transmitter model that raises tx_busy one cycle after
// tx_start and holds it for 10 cycles.
module tb_uart_tx_scheduler;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       enable;
  logic       err_clr;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic [3:0] sent_count;
  logic       ack_err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .DATA_W (8),
    .CNT_W  (4),
    .ACK_TO (16),
    .GAP_CYC(3)
  ) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .enable    (enable),
    .err_clr   (err_clr),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .busy      (busy),
    .sent_count(sent_count),
    .ack_err   (ack_err)
  );

  // FIFO model: registered read data, valid the cycle after a pop
  logic [7:0]  mem [0:63];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  initial fifo_data = 8'h00;
  always @(posedge clk) begin
    if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_data <= mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Transmitter model
  logic        xmit_on = 1'b0;
  int unsigned tx_left = 0;
  initial tx_busy = 1'b0;
  always @(posedge clk) begin
    if (tx_left > 0) begin
      tx_left <= tx_left - 1;
      if (tx_left == 1) tx_busy <= 1'b0;
    end else if (tx_start && xmit_on) begin
      tx_busy <= 1'b1;
      tx_left <= 10;
    end
  end

  // Observers, sampled on the falling edge
  logic [7:0]  starts[$];
  int unsigned rd_cnt = 0;
  int unsigned dbl_cnt = 0;
  int unsigned cyc = 0;
  int unsigned fall_cyc = 0;
  logic        fall_valid = 1'b0;
  int unsigned min_gap = 1000;
  logic        prev_rd = 1'b0;
  logic        prev_txb = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (tx_start) starts.push_back(tx_data);
    if (fifo_rd_en) begin
      rd_cnt = rd_cnt + 1;
      if (prev_rd) dbl_cnt = dbl_cnt + 1;
      if (fall_valid && (cyc - fall_cyc) < min_gap) min_gap = cyc - fall_cyc;
    end
    if (prev_txb && !tx_busy) begin
      fall_cyc   = cyc;
      fall_valid = 1'b1;
    end
    prev_rd  = fifo_rd_en;
    prev_txb = tx_busy;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 64] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  function automatic logic [31:0] start_at(input int k);
    return (starts.size() > k) ? 32'(starts[k]) : 32'hDEAD;
  endfunction

  task automatic wait_sent(input logic [3:0] tgt, input int budget, input string tag);
    int k = 0;
    while (sent_count !== tgt && k < budget) begin
      step(1);
      k++;
    end
    check_eq(tag, 32'(sent_count == tgt), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      step(1);
      k++;
    end
    check_eq(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_txbusy(input logic val, input int budget, input string tag);
    int k = 0;
    while (tx_busy !== val && k < budget) begin
      step(1);
      k++;
    end
    check_eq(tag, 32'(tx_busy), 32'(val));
  endtask

  task automatic wait_start(input int budget, input string tag);
    int k = 0;
    while (tx_start !== 1'b1 && k < budget) begin
      step(1);
      k++;
    end
    check_eq(tag, 32'(tx_start), 32'd1);
  endtask

  initial begin
    int s0;
    int unsigned r0;
    int k;

    n_reset = 1'b0;
    enable  = 1'b0;
    err_clr = 1'b0;
    step(3);

    // Reset state
    check_eq("rst_busy",  32'(busy),       32'd0);
    check_eq("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check_eq("rst_start", 32'(tx_start),   32'd0);
    check_eq("rst_data",  32'(tx_data),    32'd0);
    check_eq("rst_sent",  32'(sent_count), 32'd0);
    check_eq("rst_err",   32'(ack_err),    32'd0);
    n_reset = 1'b1;
    step(2);

    // Two bytes, normal handshake
    s0 = starts.size();
    r0 = rd_cnt;
    push(8'h41);
    push(8'h42);
    xmit_on = 1'b1;
    enable  = 1'b1;
    wait_sent(4'd2, 300, "two_sent_tmo");
    wait_idle(50, "two_idle");
    check_eq("two_byte0", start_at(s0),     32'h41);
    check_eq("two_byte1", start_at(s0 + 1), 32'h42);
    check_eq("two_pops",  rd_cnt - r0,      32'd2);
    check_eq("two_count", 32'(sent_count),  32'd2);
    check_eq("two_hold",  32'(tx_data),     32'h42);

    // Enable dropped mid-frame with three bytes queued
    s0 = starts.size();
    r0 = rd_cnt;
    push(8'h51);
    push(8'h52);
    push(8'h53);
    wait_txbusy(1'b1, 50, "dis_ack_tmo");
    enable = 1'b0;
    wait_sent(4'd3, 50, "dis_sent_tmo");
    step(40);
    check_eq("dis_pops",  rd_cnt - r0,      32'd1);
    check_eq("dis_count", 32'(sent_count),  32'd3);
    check_eq("dis_busy",  32'(busy),        32'd0);
    check_eq("dis_left",  32'(fifo_empty),  32'd0);
    enable = 1'b1;
    wait_sent(4'd5, 200, "ren_sent_tmo");
    wait_idle(50, "ren_idle");
    check_eq("ren_byte0", start_at(s0),     32'h51);
    check_eq("ren_byte1", start_at(s0 + 1), 32'h52);
    check_eq("ren_byte2", start_at(s0 + 2), 32'h53);
    check_eq("ren_pops",  rd_cnt - r0,      32'd3);

    // Acknowledge timeout
    xmit_on = 1'b0;
    push(8'h60);
    wait_start(50, "to_start_tmo");
    check_eq("to_data", 32'(tx_data), 32'h60);
    enable = 1'b0;
    step(16);
    check_eq("to_err_16", 32'(ack_err), 32'd0);
    step(1);
    check_eq("to_err_17", 32'(ack_err), 32'd1);
    check_eq("to_count",  32'(sent_count), 32'd5);
    wait_idle(20, "to_idle");
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    check_eq("clr_err", 32'(ack_err), 32'd0);

    // Timeout coinciding with err_clr: set wins
    err_clr = 1'b1;
    push(8'h61);
    enable = 1'b1;
    wait_start(50, "clr_start_tmo");
    enable = 1'b0;
    step(17);
    check_eq("clrto_err", 32'(ack_err), 32'd1);
    err_clr = 1'b0;
    step(1);
    check_eq("clrto_hold", 32'(ack_err), 32'd1);
    wait_idle(20, "clrto_idle");

    // Reset during WAIT_DONE
    xmit_on = 1'b1;
    push(8'h70);
    enable = 1'b1;
    wait_txbusy(1'b1, 50, "mr_ack_tmo");
    enable = 1'b0;
    step(2);
    n_reset = 1'b0;
    step(1);
    check_eq("mr_busy",  32'(busy),       32'd0);
    check_eq("mr_rd_en", 32'(fifo_rd_en), 32'd0);
    check_eq("mr_start", 32'(tx_start),   32'd0);
    check_eq("mr_data",  32'(tx_data),    32'd0);
    check_eq("mr_sent",  32'(sent_count), 32'd0);
    check_eq("mr_err",   32'(ack_err),    32'd0);
    step(2);
    n_reset = 1'b1;
    wait_txbusy(1'b0, 30, "mr_fall_tmo");
    step(3);
    check_eq("mr_nocount", 32'(sent_count), 32'd0);

    // 17 frames into a 4-bit counter, 3-cycle gap
    s0 = starts.size();
    for (int i = 0; i < 17; i++) push(8'(8'h80 + i));
    enable = 1'b1;
    k = 0;
    while (!(starts.size() >= s0 + 17 && busy == 1'b0 && tx_busy == 1'b0) && k < 2000) begin
      step(1);
      k++;
    end
    check_eq("wrap_done", 32'(starts.size() >= s0 + 17), 32'd1);
    check_eq("wrap_count", 32'(sent_count), 32'd1);
    check_eq("wrap_last",  32'(tx_data),    32'h90);
    check_eq("wrap_first", start_at(s0),    32'h80);
    check_eq("gap_min3",   32'(min_gap >= 3), 32'd1);
    check_eq("no_dbl_pop", dbl_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
